// File: rtl/silife_pkg.sv
// silife_pkg: shared MAX7219 register addresses, scan FSM states and the init word table
package silife_pkg;
  localparam logic [7:0] REG_DIGIT0 = 8'h01;
  localparam logic [7:0] REG_DECODE = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN = 8'h0C;
  localparam logic [7:0] REG_TEST = 8'h0F;
  localparam logic [3:0] NUM_INIT_WORDS = 4'd5;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_LATCH} state_t;
  function automatic logic [15:0] init_word(input logic [3:0] idx, input logic [3:0] intensity);
    return idx == 4'd0 ? {REG_SHUTDOWN, 8'h01} :
           idx == 4'd1 ? {REG_SCANLIMIT, 8'h07} :
           idx == 4'd2 ? {REG_DECODE, 8'h00} :
           idx == 4'd3 ? {REG_INTENSITY, 4'h0, intensity} :
                         {REG_TEST, 8'h00};
  endfunction
endpackage

// File: rtl/silife_spi_tx16.sv
// silife_spi_tx16: serialises one 16-bit MAX7219 frame (load, shift, latch) with a load/ready handshake
module silife_spi_tx16 import silife_pkg::*; #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] word,
  output logic        ready,
  output logic        done,
  output logic        sck,
  output logic        mosi,
  output logic        cs
);
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [3:0] bit_idx;
  logic ph;
  logic [15:0] sr;
  logic tick;
  assign tick = cnt == 8'(CLK_DIV - 1);
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  // next state: a load offered at the end of latch chains straight into the next frame
  always_comb begin
    state_nx = state == ST_IDLE  ? (load ? ST_LOAD : ST_IDLE) :
               state == ST_LOAD  ? ST_SHIFT :
               state == ST_SHIFT ? (tick && ph && bit_idx == 4'd15 ? ST_LATCH : ST_SHIFT) :
                                   (tick ? (load ? ST_LOAD : ST_IDLE) : ST_LATCH);
  end
  // pin outputs decoded from state so reset forces them idle immediately
  always_comb begin
    ready = state == ST_IDLE;
    done = state == ST_LATCH && tick;
    sck = state == ST_SHIFT && ph;
    mosi = state == ST_SHIFT && sr[15];
    cs = state != ST_SHIFT;
  end
  // divider, half-period phase and shift register; data moves only on the sck falling step
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      bit_idx <= '0;
      ph <= 1'b0;
      sr <= '0;
    end else if (state == ST_LOAD) begin
      sr <= word;
      cnt <= '0;
      bit_idx <= '0;
      ph <= 1'b0;
    end else if (state == ST_SHIFT || state == ST_LATCH) begin
      cnt <= tick ? 8'd0 : cnt + 8'd1;
      if (tick && state == ST_SHIFT) begin
        ph <= ~ph;
        if (ph) begin
          sr <= {sr[14:0], 1'b0};
          bit_idx <= bit_idx + 4'd1;
        end
      end
    end
endmodule

// File: rtl/silife_max7219_scan.sv
// silife_max7219_scan: walks the cell matrix rows and streams them to a MAX7219, with init on first refresh
module silife_max7219_scan import silife_pkg::*; #(
  parameter int         CLK_DIV   = 2,
  parameter logic [3:0] INTENSITY = 4'hF,
  parameter int         WIDTH     = 8,
  parameter int         HEIGHT    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      frame_done,
  output logic [$clog2(HEIGHT)-1:0] row_select,
  input  logic [WIDTH-1:0]          cells,
  output logic                      sck,
  output logic                      mosi,
  output logic                      cs
);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [3:0] LAST = NUM_INIT_WORDS + 4'(HEIGHT - 1);
  logic [3:0] word_idx, nxt_idx;
  logic init_done, ready, done, accept, adv, load;
  logic [15:0] word;
  silife_spi_tx16 #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk(clk), .reset(reset), .load(load), .word(word),
    .ready(ready), .done(done), .sck(sck), .mosi(mosi), .cs(cs)
  );
  // sequencer decisions and the frame for the current word
  always_comb begin
    accept = start && ready && !busy && !frame_done;
    adv = done && word_idx != LAST;
    load = accept || adv;
    nxt_idx = word_idx + 4'd1;
    word = word_idx < NUM_INIT_WORDS ? init_word(word_idx, INTENSITY)
         : {REG_DIGIT0 + 8'(word_idx - NUM_INIT_WORDS), cells};
  end
  // word index, row address and refresh status; row_select moves as the next LOAD is entered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      frame_done <= 1'b0;
      row_select <= '0;
      word_idx <= '0;
      init_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        busy <= 1'b1;
        word_idx <= init_done ? NUM_INIT_WORDS : 4'd0;
        if (init_done) row_select <= '0;
      end else if (adv) begin
        word_idx <= nxt_idx;
        if (nxt_idx >= NUM_INIT_WORDS) row_select <= RW'(nxt_idx - NUM_INIT_WORDS);
      end else if (done) begin
        busy <= 1'b0;
        frame_done <= 1'b1;
        init_done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_silife_max7219_scan.sv
// tb_silife_max7219_scan: decodes the SPI pins and checks refresh contents, timing and reset behaviour
module tb_silife_max7219_scan;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done, sck, mosi, cs;
  logic [2:0] row_select;
  logic [7:0] cells;
  logic busy1, frame_done1, sck1, mosi1, cs1;
  logic [2:0] row_select1;
  logic [7:0] cells1;
  logic [7:0] mem [8];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] words[$], exp_q[$], words1[$];
  int bits[$], falls[$], falls1[$];
  logic [2:0] rs_fall[$], rs_rise[$];
  logic [15:0] sh = '0, sh1 = '0;
  int nbits = 0;
  int viol = 0;
  int fd_cnt = 0;
  logic p_sck = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, p_sck1 = 1'b0, p_cs1 = 1'b1;

  assign cells = mem[row_select];
  assign cells1 = mem[row_select1];

  silife_max7219_scan dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .row_select(row_select), .cells(cells), .sck(sck), .mosi(mosi), .cs(cs)
  );
  silife_max7219_scan #(.CLK_DIV(1), .INTENSITY(4'h3)) dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy1), .frame_done(frame_done1),
    .row_select(row_select1), .cells(cells1), .sck(sck1), .mosi(mosi1), .cs(cs1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) nbits = 0;
    else begin
      if (!p_sck && sck) begin
        sh = {sh[14:0], mosi};
        nbits++;
        if (mosi !== p_mosi) viol++;
      end else if (p_sck && sck && mosi !== p_mosi) viol++;
      if (p_cs && !cs) begin
        falls.push_back(cyc);
        rs_fall.push_back(row_select);
      end
      if (!p_cs && cs) begin
        if (sck) viol++;
        words.push_back(sh);
        bits.push_back(nbits);
        rs_rise.push_back(row_select);
        nbits = 0;
      end
      if (frame_done) fd_cnt++;
    end
    p_sck = sck;
    p_cs = cs;
    p_mosi = mosi;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (!p_sck1 && sck1) sh1 = {sh1[14:0], mosi1};
      if (p_cs1 && !cs1) falls1.push_back(cyc);
      if (!p_cs1 && cs1) words1.push_back(sh1);
    end
    p_sck1 = sck1;
    p_cs1 = cs1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void build(input bit with_init, input logic [3:0] inten);
    exp_q.delete();
    if (with_init) exp_q = '{16'h0C01, 16'h0B07, 16'h0900, {12'h0A0, inten}, 16'h0F00};
    for (int r = 0; r < 8; r++) exp_q.push_back({8'(r + 1), mem[r]});
  endfunction

  task automatic clear_q();
    words.delete();
    bits.delete();
    falls.delete();
    rs_fall.delete();
    rs_rise.delete();
  endtask

  task automatic check_words(input string tag);
    int off;
    chk({tag, "_count"}, words.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < words.size(); i++) begin
      chk($sformatf("%s_word%0d", tag, i), words[i], exp_q[i]);
      chk($sformatf("%s_bits%0d", tag, i), bits[i], 16);
    end
    off = exp_q.size() - 8;
    for (int r = 0; r < 8 && off + r < rs_rise.size() && off + r < rs_fall.size(); r++) begin
      chk($sformatf("%s_rs_load%0d", tag, r), rs_fall[off + r], r);
      chk($sformatf("%s_rs_latch%0d", tag, r), rs_rise[off + r], r);
    end
  endtask

  task automatic refresh(input string tag, input bit spam, input int exp_cycles);
    int n = 0;
    int fd0 = fd_cnt;
    clear_q();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    while (!frame_done && n < 3000) begin
      @(negedge clk);
      n++;
      start = spam && (n % 37 == 5);
    end
    chk({tag, "_fd_latency"}, n, exp_cycles);
    chk({tag, "_busy_at_fd"}, busy, 0);
    start = spam;
    @(negedge clk) start = 1'b0;
    chk({tag, "_fd_one_cycle"}, frame_done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    repeat (5) @(negedge clk);
    chk({tag, "_fd_pulses"}, fd_cnt - fd0, 1);
    chk({tag, "_stays_idle"}, {busy, cs, sck}, 3'b010);
    check_words(tag);
  endtask

  initial begin
    int n;
    for (int r = 0; r < 8; r++) mem[r] = 8'($urandom);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {sck, mosi, cs, busy, frame_done}, 5'b00100);
    chk("reset_row_select", row_select, 0);

    build(1'b1, 4'hF);
    refresh("first", 1'b0, 13 * 67);
    if (falls.size() >= 2) chk("word_period", falls[1] - falls[0], 67);
    else chk("word_period_count", falls.size(), 2);
    chk("dut1_count", words1.size(), 13);
    if (words1.size() >= 13) begin
      chk("dut1_intensity_word", words1[3], 16'h0A03);
      chk("dut1_row7", words1[12], {8'h08, mem[7]});
    end
    if (falls1.size() >= 2) chk("dut1_word_period", falls1[1] - falls1[0], 34);
    else chk("dut1_period_count", falls1.size(), 2);

    mem[0] = 8'h81;
    mem[7] = 8'h3C;
    for (int r = 1; r < 7; r++) mem[r] = 8'($urandom);
    build(1'b0, 4'hF);
    refresh("second", 1'b0, 8 * 67);
    if (words.size() == 8) begin
      chk("second_row0_81", words[0], 16'h0181);
      chk("second_row7_3c", words[7], 16'h083C);
    end

    for (int r = 0; r < 8; r++) mem[r] = 8'($urandom);
    build(1'b0, 4'hF);
    refresh("spam", 1'b1, 8 * 67);

    clear_q();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!(words.size() == 3 && nbits >= 5) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("row3_reached", words.size(), 3);
    chk("row3_select", row_select, 3);
    chk("row3_cs_low", cs, 0);
    reset = 1'b1;
    #1;
    chk("mid_reset_pins", {cs, sck, busy, frame_done}, 4'b1000);
    chk("mid_reset_row_select", row_select, 0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {busy, cs}, 2'b01);

    for (int r = 0; r < 8; r++) mem[r] = 8'($urandom);
    build(1'b1, 4'hF);
    refresh("post_reset", 1'b0, 13 * 67);
    chk("mosi_cs_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
